// File: rtl/mem_request_arbiter.sv
// Shares one memory port between instruction fetch and load/store accesses.
// A data access always finishes (or is aborted by the watchdog) before the next fetch.
module mem_request_arbiter #(
  parameter logic [31:0] INIT_INSTR = 32'h0000_0013,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [31:0] PCaddr,
  input  logic        dmmRead,
  input  logic        dmmWrite,
  input  logic [31:0] dmmaddr,
  input  logic [31:0] dmmstore,
  input  logic [3:0]  dmmsel,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        iready,
  output logic [31:0] instr,
  output logic        dready,
  output logic [31:0] dmmload,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_sel,
  output logic        timeout_err
);

  typedef enum logic [1:0] {StIdle, StFetch, StData} state_e;

  // Counter value on the last cycle a request may wait before it is dropped.
  localparam logic [15:0] CntLast = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        data_done_q, data_done_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] dmmload_q, dmmload_d;
  logic        terr_q, terr_d;
  logic        expired;

  assign expired = (cnt_q == CntLast);

  always_comb begin
    state_d     = state_q;
    data_done_d = data_done_q;
    cnt_d       = 16'd0;
    instr_d     = instr_q;
    dmmload_d   = dmmload_q;
    terr_d      = terr_q;
    iready      = 1'b0;
    dready      = 1'b0;
    mem_ren     = 1'b0;
    mem_wen     = 1'b0;
    mem_addr    = 32'h0;
    mem_wdata   = 32'h0;
    mem_sel     = 4'h0;

    unique case (state_q)
      StIdle: begin
        state_d = ((dmmRead || dmmWrite) && !data_done_q) ? StData : StFetch;
      end

      StFetch: begin
        mem_ren  = 1'b1;
        mem_addr = PCaddr;
        mem_sel  = 4'hF;
        if (mem_ack) begin
          iready      = 1'b1;
          instr_d     = mem_rdata;
          data_done_d = 1'b0;
          state_d     = StIdle;
        end else if (expired) begin
          // Dropped fetch is retried from idle; instr keeps its old value.
          terr_d  = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      StData: begin
        mem_ren   = dmmRead;
        mem_wen   = dmmWrite & ~dmmRead;
        mem_addr  = dmmaddr;
        mem_wdata = dmmstore;
        mem_sel   = dmmsel;
        if (mem_ack) begin
          dready      = 1'b1;
          data_done_d = 1'b1;
          state_d     = StIdle;
          if (dmmRead) begin
            dmmload_d = mem_rdata;
          end
        end else if (expired) begin
          // Aborted access still counts as done so the core can move on.
          terr_d      = 1'b1;
          data_done_d = 1'b1;
          state_d     = StIdle;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      data_done_q <= 1'b0;
      cnt_q       <= 16'd0;
      instr_q     <= INIT_INSTR;
      dmmload_q   <= 32'h0;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_done_q <= data_done_d;
      cnt_q       <= cnt_d;
      instr_q     <= instr_d;
      dmmload_q   <= dmmload_d;
      terr_q      <= terr_d;
    end
  end

  assign instr       = instr_q;
  assign dmmload     = dmmload_q;
  assign timeout_err = terr_q;

endmodule
